branch_target_buffer: RTL and testbench

Fetch-stage branch predictor storage: a direct-mapped table of tag, target and 2-bit saturating-counter state, indexed by the fetch PC. It supplies the predicted next PC in the same cycle and registers the looked-up counter state into the decode stage as `branch_state_d`. The branch-resolution FSM in decode writes it back through `update_valid`, `update_address`, `update_target` and `update_state`, closing the predict/resolve loop.

---
 rtl/branch_target_buffer.sv | 132 +++++++++++++
 tb/tb_branch_target_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// branch_target_buffer
// Direct-mapped branch target buffer for the fetch stage. Each entry holds a
// valid bit, tag, 32-bit target and 2-bit saturating-counter state. Lookup is
// combinational from the registered table. The looked-up state and taken
// prediction are registered into decode through the F/D prediction register.
// The resolution FSM in decode writes entries back through the update port.
//
// Optional feature: define BTB_BYPASS_EN so that a lookup forwards a
// same-cycle update to the same index. When it is undefined, such a lookup
// sees the table contents from before the update.
module branch_target_buffer #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] fetch_pc,
  output logic        hit,
  output logic        predict_taken,
  output logic [1:0]  branch_state_f,
  output logic [31:0] next_fetch_pc,
  output logic [1:0]  branch_state_d,
  output logic        predict_taken_d,
  input  logic        update_valid,
  input  logic [31:0] update_address,
  input  logic [31:0] update_target,
  input  logic [1:0]  update_state
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  // Table storage
  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         state_q  [ENTRIES];

  // F/D prediction register
  logic [1:0] fd_state_q, fd_state_d;
  logic       fd_taken_q, fd_taken_d;

  // Address fields. PC bits [1:0] carry no information for word-aligned code.
  logic [IDX-1:0]  fetch_idx, upd_idx;
  logic [TAGW-1:0] fetch_tag, upd_tag;
  logic            unused_pc_bits;

  assign fetch_idx      = fetch_pc[IDX+1:2];
  assign fetch_tag      = fetch_pc[31:IDX+2];
  assign upd_idx        = update_address[IDX+1:2];
  assign upd_tag        = update_address[31:IDX+2];
  assign unused_pc_bits = ^{fetch_pc[1:0], update_address[1:0]};

  // Selected entry fields, optionally forwarded from a same-cycle update
  logic            lk_valid;
  logic [TAGW-1:0] lk_tag;
  logic [31:0]     lk_target;
  logic [1:0]      lk_state;

  // Valid bits: the only reset table state; reset wins over an update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      valid_q <= '0;
    end else if (update_valid) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Entry payload write; allocation and alias replacement are the same write.
  always_ff @(posedge clk) begin
    // NOTE: tag/target/state are left unreset on purpose; a cleared valid bit
    // masks them, and skipping reset lets the payload map to plain RAM.
    if (update_valid && !rst) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= update_target;
      state_q[upd_idx]  <= update_state;
    end
  end

  // Combinational lookup and next-PC prediction
  always_comb begin
    // NOTE: every output gets a value before any branching, so no path through
    // this block can leave a latch behind.
    lk_valid  = valid_q[fetch_idx];
    lk_tag    = tag_q[fetch_idx];
    lk_target = target_q[fetch_idx];
    lk_state  = state_q[fetch_idx];
`ifdef BTB_BYPASS_EN
    if (update_valid && (upd_idx == fetch_idx)) begin
      lk_valid  = 1'b1;
      lk_tag    = upd_tag;
      lk_target = update_target;
      lk_state  = update_state;
    end
`endif
    hit            = lk_valid && (lk_tag == fetch_tag);
    branch_state_f = hit ? lk_state : 2'b00;
    predict_taken  = hit & branch_state_f[1];
    next_fetch_pc  = predict_taken ? lk_target : (fetch_pc + 32'd4);
  end

  // F/D register next state: flush clears, stall holds, otherwise capture
  always_comb begin
    fd_state_d = branch_state_f;
    fd_taken_d = predict_taken;
    if (flush) begin
      fd_state_d = 2'b00;
      fd_taken_d = 1'b0;
    end else if (stall) begin
      fd_state_d = fd_state_q;
      fd_taken_d = fd_taken_q;
    end
  end

  // F/D register; reset has top priority
  always_ff @(posedge clk) begin
    if (rst) begin
      fd_state_q <= 2'b00;
      fd_taken_q <= 1'b0;
    end else begin
      fd_state_q <= fd_state_d;
      fd_taken_q <= fd_taken_d;
    end
  end

  assign branch_state_d  = fd_state_q;
  assign predict_taken_d = fd_taken_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed testbench for branch_target_buffer (ENTRIES=16). Expected values
// go onto a scoreboard when stimulus is driven. Combinational expectations are
// checked once the lookup settles. Registered expectations are checked just
// after the next rising edge.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [31:0] fetch_pc;
  logic        hit, predict_taken;
  logic [1:0]  branch_state_f;
  logic [31:0] next_fetch_pc;
  logic [1:0]  branch_state_d;
  logic        predict_taken_d;
  logic        update_valid;
  logic [31:0] update_address, update_target;
  logic [1:0]  update_state;

  branch_target_buffer #(.ENTRIES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .fetch_pc       (fetch_pc),
    .hit            (hit),
    .predict_taken  (predict_taken),
    .branch_state_f (branch_state_f),
    .next_fetch_pc  (next_fetch_pc),
    .branch_state_d (branch_state_d),
    .predict_taken_d(predict_taken_d),
    .update_valid   (update_valid),
    .update_address (update_address),
    .update_target  (update_target),
    .update_state   (update_state)
  );

  always #5 clk = ~clk;

  typedef enum {S_HIT, S_PT, S_BSF, S_NPC, S_BSD, S_PTD} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      S_HIT:   return {31'b0, hit};
      S_PT:    return {31'b0, predict_taken};
      S_BSF:   return {30'b0, branch_state_f};
      S_NPC:   return next_fetch_pc;
      S_BSD:   return {30'b0, branch_state_d};
      default: return {31'b0, predict_taken_d};
    endcase
  endfunction

  // Pop and compare every pending entry of one scoreboard queue
  task automatic drain(input bit registered);
    exp_t        e;
    logic [31:0] obs;
    while ((registered ? reg_q.size() : comb_q.size()) > 0) begin
      e   = registered ? reg_q.pop_front() : comb_q.pop_front();
      obs = observe(e.sel);
      n_checks++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s (%s): observed %h expected %h", e.tag, e.sel.name(), obs, e.val);
      end
    end
  endtask

  task automatic push_comb(input string tag, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = s; e.val = v;
    comb_q.push_back(e);
  endtask

  task automatic push_reg(input string tag, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = s; e.val = v;
    reg_q.push_back(e);
  endtask

  task automatic exp_miss(input string tag, input logic [31:0] pc);
    push_comb(tag, S_HIT, 32'd0);
    push_comb(tag, S_PT,  32'd0);
    push_comb(tag, S_BSF, 32'd0);
    push_comb(tag, S_NPC, pc + 32'd4);
  endtask

  task automatic exp_hit(input string tag, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [1:0] st);
    push_comb(tag, S_HIT, 32'd1);
    push_comb(tag, S_PT,  {31'b0, st[1]});
    push_comb(tag, S_BSF, {30'b0, st});
    push_comb(tag, S_NPC, st[1] ? tgt : pc + 32'd4);
  endtask

  task automatic exp_reg(input string tag, input logic [1:0] st, input logic tk);
    push_reg(tag, S_BSD, {30'b0, st});
    push_reg(tag, S_PTD, {31'b0, tk});
  endtask

  // Let the lookup settle, then check combinational expectations
  task automatic settle();
    #1;
    drain(1'b0);
  endtask

  // Advance one clock, then check registered expectations
  task automatic cycle();
    @(posedge clk);
    #1;
    drain(1'b1);
  endtask

  task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic [1:0] s);
    update_valid   = 1'b1;
    update_address = a;
    update_target  = t;
    update_state   = s;
  endtask

  task automatic no_upd();
    update_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    fetch_pc = 32'h0; update_valid = 1'b0;
    update_address = 32'h0; update_target = 32'h0; update_state = 2'b00;
    cycle();
    cycle();
    rst = 1'b0;

    // Empty table after reset
    fetch_pc = 32'h0040_0010;
    exp_miss("reset_miss", fetch_pc);
    exp_reg("reset_fd", 2'b00, 1'b0);
    settle();
    cycle();

    // Allocate idx 4 (weakly taken) while fetching an unrelated miss
    upd(32'h0040_0010, 32'h0040_0100, 2'b10);
    fetch_pc = 32'h0040_0080;
    exp_miss("alloc_other_miss", fetch_pc);
    settle();
    cycle();
    no_upd();
    fetch_pc = 32'h0040_0010;
    exp_hit("alloc_hit", fetch_pc, 32'h0040_0100, 2'b10);
    exp_reg("alloc_fd", 2'b10, 1'b1);
    settle();
    cycle();

    // Alias on idx 4 with a different tag
    fetch_pc = 32'h0040_0050;
    exp_miss("alias_miss", fetch_pc);
    exp_reg("alias_fd", 2'b00, 1'b0);
    settle();
    cycle();

    // Retrain idx 4 to weakly not-taken
    upd(32'h0040_0010, 32'h0040_0100, 2'b01);
    fetch_pc = 32'h0040_0080;
    settle();
    cycle();
    no_upd();
    fetch_pc = 32'h0040_0010;
    exp_hit("wnt_hit", fetch_pc, 32'h0040_0100, 2'b01);
    exp_reg("wnt_fd", 2'b01, 1'b0);
    settle();
    cycle();

    // Same-cycle update and fetch on idx 8
    upd(32'h0040_0020, 32'h0040_0200, 2'b11);
    fetch_pc = 32'h0040_0020;
`ifdef BTB_BYPASS_EN
    exp_hit("bypass_same_cycle", fetch_pc, 32'h0040_0200, 2'b11);
    exp_reg("bypass_fd", 2'b11, 1'b1);
`else
    exp_miss("nobypass_same_cycle", fetch_pc);
    exp_reg("nobypass_fd", 2'b00, 1'b0);
`endif
    settle();
    cycle();
    no_upd();
    exp_hit("after_same_cycle", fetch_pc, 32'h0040_0200, 2'b11);
    exp_reg("after_same_cycle_fd", 2'b11, 1'b1);
    settle();
    cycle();

    // Put 10 into the F/D register, then stall for 3 cycles
    upd(32'h0040_0030, 32'h0040_0300, 2'b10);
    fetch_pc = 32'h0040_0080;
    settle();
    cycle();
    no_upd();
    fetch_pc = 32'h0040_0030;
    exp_hit("stall_setup", fetch_pc, 32'h0040_0300, 2'b10);
    exp_reg("stall_setup_fd", 2'b10, 1'b1);
    settle();
    cycle();
    stall = 1'b1;
    fetch_pc = 32'h0040_0020;
    exp_reg("stall1", 2'b10, 1'b1);
    settle();
    cycle();
    fetch_pc = 32'h0040_0010;
    exp_reg("stall2", 2'b10, 1'b1);
    settle();
    cycle();
    fetch_pc = 32'h0040_0080;
    exp_reg("stall3", 2'b10, 1'b1);
    settle();
    cycle();
    flush = 1'b1;
    fetch_pc = 32'h0040_0020;
    exp_reg("flush_over_stall", 2'b00, 1'b0);
    settle();
    cycle();
    stall = 1'b0;

    // Back-to-back updates to idx 1 under flush; the later one wins
    upd(32'h0040_0044, 32'h0000_1000, 2'b11);
    fetch_pc = 32'h0040_0080;
    exp_reg("flush_only_fd", 2'b00, 1'b0);
    settle();
    cycle();
    upd(32'h0050_0044, 32'h0000_2000, 2'b01);
    settle();
    cycle();
    no_upd();
    flush = 1'b0;
    fetch_pc = 32'h0040_0044;
    exp_miss("b2b_first_replaced", fetch_pc);
    settle();
    cycle();
    fetch_pc = 32'h0050_0044;
    exp_hit("b2b_second_wins", fetch_pc, 32'h0000_2000, 2'b01);
    settle();
    cycle();

    // 32-bit wrap of the sequential next PC
    fetch_pc = 32'hFFFF_FFFC;
    exp_miss("pc_wrap", fetch_pc);
    settle();
    cycle();

    // Reset together with an update empties the table
    fetch_pc = 32'h0040_0030;
    rst = 1'b1;
    upd(32'h0040_0060, 32'h0040_0600, 2'b11);
    exp_reg("rst_fd", 2'b00, 1'b0);
    settle();
    cycle();
    rst = 1'b0;
    no_upd();
    fetch_pc = 32'h0040_0010; exp_miss("rst_miss_10", fetch_pc); settle(); cycle();
    fetch_pc = 32'h0040_0020; exp_miss("rst_miss_20", fetch_pc); settle(); cycle();
    fetch_pc = 32'h0040_0030; exp_miss("rst_miss_30", fetch_pc); settle(); cycle();
    fetch_pc = 32'h0050_0044; exp_miss("rst_miss_44", fetch_pc); settle(); cycle();
    fetch_pc = 32'h0040_0060; exp_miss("rst_miss_upd", fetch_pc); settle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
